// File: rtl/oam_dma_if.sv
// ============================================================================
//  Module      : oam_dma_if
//  Description : Bus bundle for the OAM sprite DMA engine. It groups the CPU
//                snoop and halt lines with the DMA-owned bus signals.
//                The master modport is the DMA engine. The slave modport is
//                the surrounding system (CPU plus memory).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface oam_dma_if;
  // CPU side: the engine watches these lines for the trigger write.
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic        cpu_rw_n;

  // Status lines going back to the CPU.
  logic        rdy;
  logic        busy;

  // DMA-owned bus cycle.
  logic        dma_bus_en;
  logic [15:0] dma_addr;
  logic        dma_rw_n;
  logic [7:0]  dma_wdata;
  logic [7:0]  dma_rdata;

  modport master (
    input  cpu_addr,
    input  cpu_data,
    input  cpu_rw_n,
    input  dma_rdata,
    output rdy,
    output busy,
    output dma_bus_en,
    output dma_addr,
    output dma_rw_n,
    output dma_wdata
  );

  modport slave (
    output cpu_addr,
    output cpu_data,
    output cpu_rw_n,
    output dma_rdata,
    input  rdy,
    input  busy,
    input  dma_bus_en,
    input  dma_addr,
    input  dma_rw_n,
    input  dma_wdata
  );
endinterface

`default_nettype wire

// File: rtl/oam_dma.sv
// ============================================================================
//  Module      : oam_dma
//  Description : OAM sprite DMA engine. A CPU write to TRIGGER_ADDR halts
//                the CPU. The engine then copies the 256 bytes of page
//                {data,00..FF} to OAM_DATA_ADDR, one read/write pair per
//                byte.
//                Optional feature macro: OAM_DMA_ALIGN_EN. When it is
//                defined, the engine inserts one idle ALIGN cycle after
//                HALT when the free-running parity bit is odd.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module oam_dma #(
  parameter logic [15:0] TRIGGER_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input  wire logic  phi0,
  input  wire logic  reset,
  oam_dma_if.master  bus
);

  // State encoding. ALIGN exists only when the alignment feature is built in.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    READ  = 3'd2,
    WRITE = 3'd3
`ifdef OAM_DMA_ALIGN_EN
    ,
    ALIGN = 3'd4
`endif
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [7:0]  page;
  logic [7:0]  index;
  logic [7:0]  data;
  logic        trigger;

`ifdef OAM_DMA_ALIGN_EN
  logic        parity;
`endif

  // A trigger is a CPU write to the trigger address. Being in IDLE is the
  // same condition as rdy being high, so a write while busy is ignored.
  assign trigger = (state == IDLE) &&
                   (bus.cpu_addr == TRIGGER_ADDR) &&
                   !bus.cpu_rw_n;

  // State register. Reset wins over a trigger on the same edge.
  always_ff @(posedge phi0) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Transfer datapath: page/index latch, read-data capture, index advance.
  always_ff @(posedge phi0) begin
    if (reset) begin
      page  <= 8'h00;
      index <= 8'h00;
      data  <= 8'h00;
    end else begin
      if (trigger) begin
        page  <= bus.cpu_data;
        index <= 8'h00;
      end
      if (state == READ) begin
        data <= bus.dma_rdata;
      end
      if (state == WRITE) begin
        // 8-bit wrap keeps the transfer inside the page; no carry into page.
        index <= index + 8'd1;
      end
    end
  end

`ifdef OAM_DMA_ALIGN_EN
  // Free-running parity bit. It toggles every edge regardless of state.
  always_ff @(posedge phi0) begin
    if (reset) begin
      parity <= 1'b0;
    end else begin
      parity <= ~parity;
    end
  end
`endif

  // Next-state decode and per-state bus drive. Idle bus drives are the defaults.
  always_comb begin
    next_state     = state;
    bus.dma_bus_en = 1'b0;
    bus.dma_addr   = 16'h0000;
    bus.dma_rw_n   = 1'b1;

    case (state)
      IDLE: begin
        if (trigger) begin
          next_state = HALT;
        end
      end

      HALT: begin
`ifdef OAM_DMA_ALIGN_EN
        next_state = parity ? ALIGN : READ;
`else
        next_state = READ;
`endif
      end

`ifdef OAM_DMA_ALIGN_EN
      ALIGN: begin
        next_state = READ;
      end
`endif

      READ: begin
        bus.dma_bus_en = 1'b1;
        bus.dma_addr   = {page, index};
        next_state     = WRITE;
      end

      WRITE: begin
        bus.dma_bus_en = 1'b1;
        bus.dma_addr   = OAM_DATA_ADDR;
        bus.dma_rw_n   = 1'b0;
        next_state     = (index == 8'hFF) ? IDLE : READ;
      end

      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Status lines follow the state. Write data comes straight from the
  // captured byte, so it keeps its last value between transfers.
  always_comb begin
    bus.rdy       = (state == IDLE);
    bus.busy      = (state != IDLE);
    bus.dma_wdata = data;
  end

endmodule

`default_nettype wire
